// File: rtl/player_action_pkg.sv
// Shared types and constants for the per-player action controller.
package player_action_pkg;

  typedef enum logic [2:0] {
    ACT_STAND       = 3'd0,
    ACT_JUMP        = 3'd1,
    ACT_DOUBLE_JUMP = 3'd2,
    ACT_RUN         = 3'd3,
    ACT_SPRINT      = 3'd4
  } action_e;

  localparam int unsigned BTN_X = 2;
  localparam int unsigned BTN_Y = 1;
  localparam int unsigned BTN_B = 0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_action_chan.sv
// One player's action FSM with button edge detection and airtime/run counters.
// Sprint promotion is built only when PLAYER_ACTION_SPRINT_EN is defined.
module player_action_chan
  import player_action_pkg::*;
#(
  parameter int unsigned JUMP_CYCLES   = 8,
  parameter int unsigned DJ_WINDOW     = 4,
  parameter int unsigned SPRINT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] buttons,
  output logic [2:0] action,
  output logic       airborne
);

  localparam int unsigned CW = $clog2(max_u(JUMP_CYCLES, SPRINT_CYCLES) + 1);

  action_e       state_q, state_d;
  logic [CW-1:0] air_q, air_d;
  logic          prev_x, prev_b;
  logic          x_edge, b_edge, y_lvl;
`ifdef PLAYER_ACTION_SPRINT_EN
  logic [CW-1:0] run_q, run_d;
`endif

  assign x_edge = buttons[BTN_X] & ~prev_x;
  assign b_edge = buttons[BTN_B] & ~prev_b;
  assign y_lvl  = buttons[BTN_Y];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACT_STAND;
      air_q   <= '0;
      prev_x  <= 1'b0;
      prev_b  <= 1'b0;
`ifdef PLAYER_ACTION_SPRINT_EN
      run_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      air_q   <= air_d;
      prev_x  <= buttons[BTN_X];
      prev_b  <= buttons[BTN_B];
`ifdef PLAYER_ACTION_SPRINT_EN
      run_q   <= run_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    air_d   = air_q;
`ifdef PLAYER_ACTION_SPRINT_EN
    run_d   = run_q;
`endif
    case (state_q)
      ACT_STAND: begin
        if (x_edge) begin
          state_d = ACT_JUMP;
          air_d   = '0;
        end else if (y_lvl) begin
          state_d = ACT_RUN;
`ifdef PLAYER_ACTION_SPRINT_EN
          run_d   = '0;
`endif
        end
      end
      ACT_RUN: begin
        if (x_edge) begin
          state_d = ACT_JUMP;
          air_d   = '0;
        end else if (!y_lvl) begin
          state_d = ACT_STAND;
`ifdef PLAYER_ACTION_SPRINT_EN
        end else if (run_q == CW'(SPRINT_CYCLES - 1)) begin
          state_d = ACT_SPRINT;
        end else if (run_q != '1) begin
          run_d = run_q + CW'(1);
`endif
        end
      end
`ifdef PLAYER_ACTION_SPRINT_EN
      ACT_SPRINT: begin
        if (x_edge) begin
          state_d = ACT_JUMP;
          air_d   = '0;
        end else if (!y_lvl) begin
          state_d = ACT_STAND;
        end
      end
`endif
      ACT_JUMP, ACT_DOUBLE_JUMP: begin
        // Landing wins over a same-cycle double-jump request.
        if (air_q == CW'(JUMP_CYCLES - 1)) begin
          state_d = y_lvl ? ACT_RUN : ACT_STAND;
          air_d   = '0;
`ifdef PLAYER_ACTION_SPRINT_EN
          run_d   = '0;
`endif
        end else if (state_q == ACT_JUMP && b_edge && air_q < CW'(DJ_WINDOW)) begin
          state_d = ACT_DOUBLE_JUMP;
          air_d   = '0;
        end else if (air_q != '1) begin
          air_d = air_q + CW'(1);
        end
      end
      default: state_d = ACT_STAND;
    endcase
  end

  assign action   = state_q;
  assign airborne = (state_q == ACT_JUMP) || (state_q == ACT_DOUBLE_JUMP);

endmodule

// File: rtl/player_action_ctrl.sv
// Multi-player action controller: one independent player_action_chan per player.
// Define PLAYER_ACTION_SPRINT_EN to enable RUN -> SPRINT promotion.
module player_action_ctrl
  import player_action_pkg::*;
#(
  parameter int unsigned N_PLAYERS     = 2,
  parameter int unsigned JUMP_CYCLES   = 8,
  parameter int unsigned DJ_WINDOW     = 4,
  parameter int unsigned SPRINT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3*N_PLAYERS-1:0] buttons,
  output logic [3*N_PLAYERS-1:0] action,
  output logic [N_PLAYERS-1:0]   airborne
);

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_chan
    player_action_chan #(
      .JUMP_CYCLES  (JUMP_CYCLES),
      .DJ_WINDOW    (DJ_WINDOW),
      .SPRINT_CYCLES(SPRINT_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .buttons (buttons[3*p +: 3]),
      .action  (action[3*p +: 3]),
      .airborne(airborne[p])
    );
  end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Self-checking bench for player_action_ctrl: timestamp-based reference model plus directed literals.
module tb_player_action_ctrl;

  localparam int N   = 2;
  localparam int JC  = 8;
  localparam int DJW = 4;
  localparam int SC  = 16;
`ifdef PLAYER_ACTION_SPRINT_EN
  localparam int SPRINT_EN = 1;
`else
  localparam int SPRINT_EN = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3*N-1:0] buttons = '0;
  logic [3*N-1:0] action;
  logic [N-1:0]   airborne;

  int checks = 0;
  int errors = 0;

  player_action_ctrl #(
    .N_PLAYERS    (N),
    .JUMP_CYCLES  (JC),
    .DJ_WINDOW    (DJW),
    .SPRINT_CYCLES(SC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .action  (action),
    .airborne(airborne)
  );

  always #5 clk = ~clk;

  // Model: mode 0..4 uses the output encoding; t0 = take-off edge, r0 = run-start edge.
  int m_mode [N];
  int m_t0   [N];
  int m_r0   [N];
  int m_px   [N];
  int m_pb   [N];
  int edge_n = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_n = 0;
      for (int p = 0; p < N; p++) begin
        m_mode[p] = 0; m_t0[p] = 0; m_r0[p] = 0; m_px[p] = 0; m_pb[p] = 0;
      end
    end else begin
      edge_n++;
      for (int p = 0; p < N; p++) begin
        int x, y, b, xe, be, age;
        x  = int'(buttons[3*p+2]);
        y  = int'(buttons[3*p+1]);
        b  = int'(buttons[3*p]);
        xe = x & ~m_px[p] & 1;
        be = b & ~m_pb[p] & 1;
        age = edge_n - m_t0[p];
        case (m_mode[p])
          0: if (xe != 0) begin m_mode[p] = 1; m_t0[p] = edge_n; end
             else if (y != 0) begin m_mode[p] = 3; m_r0[p] = edge_n; end
          3: if (xe != 0) begin m_mode[p] = 1; m_t0[p] = edge_n; end
             else if (y == 0) m_mode[p] = 0;
             else if (SPRINT_EN != 0 && edge_n - m_r0[p] == SC) m_mode[p] = 4;
          4: if (xe != 0) begin m_mode[p] = 1; m_t0[p] = edge_n; end
             else if (y == 0) m_mode[p] = 0;
          1, 2: if (age == JC) begin
                  m_mode[p] = (y != 0) ? 3 : 0;
                  m_r0[p] = edge_n;
                end else if (m_mode[p] == 1 && be != 0 && age <= DJW) begin
                  m_mode[p] = 2; m_t0[p] = edge_n;
                end
          default: m_mode[p] = 0;
        endcase
        m_px[p] = x;
        m_pb[p] = b;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int p = 0; p < N; p++) begin
        check($sformatf("model p%0d action", p), int'(action[3*p +: 3]), m_mode[p]);
        check($sformatf("model p%0d airborne", p), int'(airborne[p]),
              (m_mode[p] == 1 || m_mode[p] == 2) ? 1 : 0);
      end
    end
  end

  task automatic drive(input logic [2:0] b0, input logic [2:0] b1, input int n);
    buttons = {b1, b0};
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] rb [N];

  initial begin
    repeat (2) @(negedge clk);
    check("reset action", int'(action), 0);
    check("reset airborne", int'(airborne), 0);
    reset = 1'b1;

    // Single jump: 8 cycles airborne then stand; p1 untouched
    drive(3'b100, 3'b000, 1);
    check("jump entry", int'(action[2:0]), 1);
    drive(3'b000, 3'b000, 7);
    check("jump last cycle", int'(action[2:0]), 1);
    check("jump airborne", int'(airborne[0]), 1);
    drive(3'b000, 3'b000, 1);
    check("jump landed", int'(action[2:0]), 0);
    check("p1 idle", int'(action[5:3]), 0);

    // Double jump two cycles after take-off; second B ignored
    drive(3'b100, 3'b000, 1);
    drive(3'b000, 3'b000, 1);
    drive(3'b001, 3'b000, 1);
    check("dj entry", int'(action[2:0]), 2);
    drive(3'b000, 3'b000, 1);
    drive(3'b001, 3'b000, 1);
    drive(3'b000, 3'b000, 5);
    check("dj last cycle", int'(action[2:0]), 2);
    drive(3'b000, 3'b000, 1);
    check("dj landed", int'(action[2:0]), 0);

    // B edge outside window
    drive(3'b100, 3'b000, 1);
    drive(3'b000, 3'b000, 4);
    drive(3'b001, 3'b000, 1);
    check("late B no dj", int'(action[2:0]), 1);
    drive(3'b000, 3'b000, 3);
    check("late B landed", int'(action[2:0]), 0);

    // Held run
    drive(3'b010, 3'b000, 1);
    check("run entry", int'(action[2:0]), 3);
    drive(3'b010, 3'b000, 15);
    check("run before sprint", int'(action[2:0]), 3);
    drive(3'b010, 3'b000, 1);
    check("sprint promotion", int'(action[2:0]), (SPRINT_EN != 0) ? 4 : 3);
    drive(3'b010, 3'b000, 3);
    drive(3'b000, 3'b000, 1);
    check("run release", int'(action[2:0]), 0);

    // X held: exactly one jump
    drive(3'b100, 3'b000, 1);
    check("held X jump", int'(action[2:0]), 1);
    drive(3'b100, 3'b000, 8);
    check("held X landed", int'(action[2:0]), 0);
    drive(3'b100, 3'b000, 5);
    check("held X no rejump", int'(action[2:0]), 0);

    // Y held at landing -> RUN
    drive(3'b000, 3'b000, 1);
    drive(3'b100, 3'b000, 1);
    drive(3'b010, 3'b000, 8);
    check("land into run", int'(action[2:0]), 3);
    drive(3'b000, 3'b000, 1);

    // Both players, same cycle
    drive(3'b100, 3'b010, 1);
    check("dual p0 jump", int'(action[2:0]), 1);
    check("dual p1 run", int'(action[5:3]), 3);
    drive(3'b001, 3'b100, 1);
    check("dual p0 dj", int'(action[2:0]), 2);
    check("dual p1 jump", int'(action[5:3]), 1);
    drive(3'b000, 3'b000, 12);

    // Randomised traffic on both channels
    rb[0] = '0; rb[1] = '0;
    repeat (800) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 3) == 0) rb[p] = 3'($urandom_range(0, 7));
      drive(rb[0], rb[1], 1);
    end
    drive(3'b000, 3'b000, 12);

    // Async reset in the middle of a double jump
    drive(3'b100, 3'b000, 1);
    drive(3'b000, 3'b000, 1);
    drive(3'b001, 3'b000, 1);
    drive(3'b000, 3'b000, 2);
    check("pre-reset dj", int'(action[2:0]), 2);
    #2 reset = 1'b0;
    #1;
    check("async reset action", int'(action), 0);
    check("async reset airborne", int'(airborne), 0);
    buttons = {3'b000, 3'b100};
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // X held through reset release counts as an edge
    drive(3'b100, 3'b000, 1);
    check("X through reset", int'(action[2:0]), 1);
    drive(3'b000, 3'b000, 10);
    check("post reset stand", int'(action[2:0]), 0);
    check("post reset airborne", int'(airborne), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_action_ctrl.md
# player_action_ctrl

Parametrised multi-player character action controller: per player, three buttons {X, Y, B} drive a registered state machine producing STAND / RUN / SPRINT / JUMP / DOUBLE_JUMP. Jumps now have finite airtime, double jump is only accepted inside a window after take-off, and a held run promotes to sprint. The block sits between the button input stage and the sprite/animation logic, with one independent channel per player.

## Interface
- N_PLAYERS, 2, number of independent player channels (≥1)
- JUMP_CYCLES, 8, airtime of JUMP and of DOUBLE_JUMP in cycles (≥2)
- DJ_WINDOW, 4, cycles after take-off during which B triggers double jump (1..JUMP_CYCLES-1)
- SPRINT_CYCLES, 16, cycles of continuous RUN before promotion to SPRINT (≥1)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- buttons  in  3*N_PLAYERS  player p at [3p+2:3p]; bit 2 = X (jump), bit 1 = Y (run), bit 0 = B (double jump)
- action  out  3*N_PLAYERS  player p at [3p+2:3p]; STAND=0, JUMP=1, DOUBLE_JUMP=2, RUN=3, SPRINT=4; 5..7 never driven
- airborne  out  N_PLAYERS  bit p high while player p is in JUMP or DOUBLE_JUMP

## Operation
- Channels fully independent; no shared state.
- X and B are edge-triggered (sampled value 1, previous sample 0); Y is level.
- STAND: X edge → JUMP; else Y → RUN; else stay.
- RUN: X edge → JUMP; Y low → STAND; Y high → run_cnt increments; run_cnt reaching SPRINT_CYCLES-1 with Y still high → SPRINT.
- SPRINT: X edge → JUMP; Y low → STAND; else stay.
- JUMP: air_cnt counts from 0. B edge while air_cnt < DJ_WINDOW → DOUBLE_JUMP, air_cnt reloaded to 0. When air_cnt = JUMP_CYCLES-1 → land: RUN if Y high, else STAND. X ignored while airborne.
- DOUBLE_JUMP: B and X ignored; lands after JUMP_CYCLES cycles by the same rule. Only one double jump per take-off.
- Priority in one cycle: landing > double-jump trigger; X edge > Y release.
- Landing into RUN starts run_cnt at 0 (no sprint credit carried through air).
- Counter width: $clog2(max(JUMP_CYCLES, SPRINT_CYCLES)+1); counters saturate, never wrap.

## Timing
- Reset (reset low, asynchronous): action = STAND (0) for all players, airborne = 0, counters = 0, previous-button registers = 0.
- Output is registered: a transition caused by inputs sampled at edge k is visible on action after edge k.
- X edge at edge k → action = JUMP for exactly JUMP_CYCLES cycles (edges k..k+JUMP_CYCLES-1), landing at edge k+JUMP_CYCLES.
- Double jump accepted at edges k+1..k+DJ_WINDOW; DOUBLE_JUMP then lasts JUMP_CYCLES cycles from its entry edge.
- RUN entered at edge r with Y held continuously → SPRINT at edge r+SPRINT_CYCLES.
- X held through reset deassertion counts as an edge on the first sampled edge (previous register cleared).
- Reset asserted mid-air: immediate STAND, airborne low, no landing transition afterwards.

## Configuration
- PLAYER_ACTION_SPRINT_EN defined: SPRINT state, run_cnt, and SPRINT_CYCLES are active as above.
- Not defined: RUN never promotes, run_cnt is not instantiated, SPRINT_CYCLES is unused, and action never takes value 4.

## Structure
- Package player_action_pkg: action_e enum (3-bit encoding above), button bit-index constants BTN_X=2, BTN_Y=1, BTN_B=0.
- Sub-module player_action_chan: one player's FSM, edge detectors, and counters.
- Top-level player_action_ctrl generates N_PLAYERS instances and slices the buses.

## Test plan
- Reset, then p0 buttons=100 for 1 cycle → JUMP for 8 cycles, airborne=1, then STAND; p1 stays STAND throughout.
- p0 X edge, B edge 2 cycles later → DOUBLE_JUMP for 8 cycles from the B edge; a second B edge is ignored; B edge at air_cnt=4 → no double jump.
- p0 Y held 20 cycles → RUN at cycle 1, SPRINT after 16 cycles; release Y → STAND next edge. With the macro undefined, action stays RUN.
- X held continuously → exactly one jump; after landing with X still held, no re-jump. Y held at landing → RUN.
- Both players stimulated with different sequences in the same cycles → action buses match independent per-player expectations.
- Reset asserted asynchronously mid-DOUBLE_JUMP → action=0 and airborne=0 immediately (before the next clk edge).
